// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX to MEM pipeline register with 2-entry skid buffer and flush (option: EX_MEM_OVF_SQUASH_EN)
module ex_mem_stage #(
  parameter int                    DATA_W       = 32,
  parameter int                    REGAD_W      = 5,
  parameter int                    CTRL_IN_W    = 16,
  parameter int                    CTRL_OUT_W   = 8,
  parameter logic [CTRL_OUT_W-1:0] CTRL_WE_MASK = 'h03
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  zero_e,
  input  logic                  ovf_e,
  input  logic [REGAD_W-1:0]    dst_e,
  input  logic [DATA_W-1:0]     alu_e,
  input  logic [DATA_W-1:0]     pc4_e,
  input  logic [CTRL_IN_W-1:0]  ctrl_e,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  zero_m,
  output logic                  ovf_m,
  output logic [REGAD_W-1:0]    dst_m,
  output logic [DATA_W-1:0]     alu_m,
  output logic [DATA_W-1:0]     pc4_m,
  output logic [CTRL_OUT_W-1:0] ctrl_m
);

  localparam int ENT_W = 2 + REGAD_W + 2 * DATA_W + CTRL_OUT_W;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ENT_W-1:0]     main_q, skid_q, in_entry;
  logic [CTRL_OUT_W-1:0] ctrl_cap;
  logic                 accept, pop;
  logic                 load_main_in, load_main_skid, load_skid;

  // Control slice as stored; overflowing instructions may lose their write enables
`ifdef EX_MEM_OVF_SQUASH_EN
  assign ctrl_cap = ovf_e ? (ctrl_e[CTRL_OUT_W-1:0] & ~CTRL_WE_MASK) : ctrl_e[CTRL_OUT_W-1:0];
`else
  logic unused_we_mask;
  assign unused_we_mask = ^CTRL_WE_MASK;
  assign ctrl_cap = ctrl_e[CTRL_OUT_W-1:0];
`endif

  // Upper control bits belong to EX only and are intentionally dropped
  if (CTRL_IN_W > CTRL_OUT_W) begin : g_ctrl_hi
    logic unused_ctrl_hi;
    assign unused_ctrl_hi = ^ctrl_e[CTRL_IN_W-1:CTRL_OUT_W];
  end

  assign in_entry = {zero_e, ovf_e, dst_e, alu_e, pc4_e, ctrl_cap};
  assign {zero_m, ovf_m, dst_m, alu_m, pc4_m, ctrl_m} = main_q;

  // Handshake decoded purely from the state register: no comb path from out_ready to in_ready
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Next-state and storage load selection; flush overrides accept and pop
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d      = S_ONE;
            load_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_d   = S_TWO;
            load_skid = 1'b1;
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d        = S_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  // Entry storage; flush only invalidates, it never clears data
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Parametrised EX→MEM pipeline stage with valid/ready handshake.
- Carries ALU result, PC+4, destination register, Zero/Overflow flags and MEM-stage control slice.
- 2-entry skid buffer: MEM back-pressure never forms a combinational ready path into EX.
- Synchronous flush for branch/exception squash.

Parameters:
DATA_W, 32, width of alu_out and pc_plus4
REGAD_W, 5, destination register address width
CTRL_IN_W, 16, width of control bundle from EX
CTRL_OUT_W, 8, low bits of control bundle forwarded to MEM (CTRL_OUT_W <= CTRL_IN_W)
CTRL_WE_MASK, 8'h03, bits of forwarded control that are write enables (used by optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous squash of all held entries
in_valid  in  1  EX presents a valid instruction
in_ready  out  1  stage can accept (registered)
zero_e  in  1  ALU zero flag
ovf_e  in  1  ALU overflow flag
dst_e  in  REGAD_W  destination register
alu_e  in  DATA_W  ALU result
pc4_e  in  DATA_W  PC+4
ctrl_e  in  CTRL_IN_W  control bundle
out_valid  out  1  MEM-side entry valid
out_ready  in  1  MEM consumes entry
zero_m, ovf_m, dst_m, alu_m, pc4_m  out  widths as inputs  registered fields
ctrl_m  out  CTRL_OUT_W  ctrl_e[CTRL_OUT_W-1:0] as captured

Behaviour:
- Storage: main entry (drives outputs) and skid entry. States: EMPTY (no entry), ONE (main valid), TWO (main + skid valid).
- Reset (async, immediate): state EMPTY; out_valid=0; in_ready=1; all data outputs 0; skid contents 0.
- Accept = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (state != TWO), from registered state only.
- EMPTY: accept → ONE, main loads input. Data is visible on outputs the cycle after accept (1-cycle latency).
- ONE, accept & pop → ONE, main reloads input.
- ONE, accept & !pop → TWO, skid loads input.
- ONE, !accept & pop → EMPTY.
- TWO (in_ready=0): pop → ONE, main loads from skid. No pop → hold.
- Ordering strictly FIFO. No entry is dropped or duplicated except by flush.
- Field capture:
  - ctrl truncates to the low CTRL_OUT_W bits at capture.
  - All other fields are copied bit-exact.
- Data fields hold their last value when invalid. Verification checks data only when out_valid=1.
- flush=1 at an edge:
  - Next state EMPTY; out_valid=0; in_ready=1.
  - Flush has priority over any simultaneous accept or pop. The accepted input is discarded.
  - Data registers are not cleared.
- rst asserted mid-transfer aborts everything immediately; no partial entry survives.
- Throughput: one entry per cycle sustained while out_ready=1.

Optional Feature:
- Macro: EX_MEM_OVF_SQUASH_EN.
- Defined:
  - At capture, if ovf_e=1, the bits of ctrl selected by CTRL_WE_MASK are forced to 0 in the stored entry (main or skid).
  - Overflowing instructions thus never write the register file or memory; ovf_m still reports 1.
- Undefined: ctrl is stored unmodified regardless of ovf_e; CTRL_WE_MASK is unused.

Test Plan:
- Reset mid-stream: load 2 entries, assert rst asynchronously between edges → out_valid=0, in_ready=1, alu_m=0 immediately.
- Streaming with out_ready=1: alu_e=1,2,3,4 on consecutive cycles → alu_m=1,2,3,4 one cycle later each; in_ready constantly 1.
- Back-pressure: out_ready=0, push A=0xAAAA then B=0xBBBB → in_ready=0 after B; raise out_ready → A then B in order, in_ready returns 1.
- Flush collision: state TWO, flush=1 with in_valid=1 and out_ready=1 → next cycle out_valid=0; neither held nor incoming data ever appears.
- Ctrl truncation: CTRL_IN_W=16, CTRL_OUT_W=8, ctrl_e=16'hA5C3 → ctrl_m=8'hC3.
- With EX_MEM_OVF_SQUASH_EN and mask 8'h03: ovf_e=1, ctrl_e low byte 8'hFF → ctrl_m=8'hFC, ovf_m=1. Without the macro → ctrl_m=8'hFF.
